// File: rtl/led_panel_pkg.sv
// Shared types and constants for the LED panel row/bit-plane scan controller.
// The on-time helper takes the base on-time explicitly because it is a parameter of the top.
package led_panel_pkg;

  localparam int ROW_W   = 4;
  localparam int PLANE_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    WAIT,
    LATCH,
    UNBLANK,
    ON,
    BLANKING,
    ADVANCE
  } state_e;

  function automatic logic [15:0] on_time(input int unsigned base_on,
                                          input logic [PLANE_W-1:0] plane);
    return 16'(base_on << plane);
  endfunction

endpackage

// File: rtl/led_panel_on_timer.sv
// Loadable down-counter that times the unblanked interval of one bit-plane.
// expired marks the final on-cycle, so the caller can re-blank on the same edge it leaves ON.
module led_panel_on_timer #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [PW-1:0] load_val,
  input  logic          dec,
  output logic [PW-1:0] value,
  output logic          expired
);

  logic [PW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign value   = count_q;
  assign expired = (count_q <= PW'(1));

endmodule

// File: rtl/led_panel_scan_ctrl.sv
// Row/bit-plane scan sequencer: drives shift requests, latch, blank and row address
// for a HUB-style panel using binary-coded modulation of the per-plane on-time.
module led_panel_scan_ctrl
  import led_panel_pkg::*;
#(
  parameter int PLANES  = 2,
  parameter int BASE_ON = 3,
  parameter int PW      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [ROW_W-1:0]   rowmax_in,
  input  logic               shift_done,
  output logic               shift_req,
  output logic [ROW_W-1:0]   row_out,
  output logic [PLANE_W-1:0] plane_out,
  output logic               latch_out,
  output logic               blank_out,
  output logic               aclk_out,
  output logic               arst_out,
  output logic               frame_tick
);

  state_e               state_q, state_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [ROW_W-1:0]     rowmax_q, rowmax_d;
  logic [PLANE_W-1:0]   plane_q, plane_d;
  logic                 shift_req_q, shift_req_d;
  logic                 latch_q, latch_d;
  logic                 blank_q, blank_d;
  logic                 aclk_q, aclk_d;
  logic                 arst_q, arst_d;
  logic                 frame_tick_q, frame_tick_d;

  logic                 on_load, on_dec, on_expired;
  logic [PW-1:0]        on_value;

  led_panel_on_timer #(.PW(PW)) u_on_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (on_load),
    .load_val (PW'(on_time(BASE_ON, plane_q))),
    .dec      (on_dec),
    .value    (on_value),
    .expired  (on_expired)
  );

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    rowmax_d     = rowmax_q;
    plane_d      = plane_q;
    shift_req_d  = 1'b0;
    latch_d      = 1'b0;
    blank_d      = 1'b1;
    aclk_d       = 1'b0;
    arst_d       = 1'b0;
    frame_tick_d = 1'b0;
    on_load      = 1'b0;
    on_dec       = 1'b0;

    case (state_q)
      IDLE: begin
        arst_d  = 1'b1;
        row_d   = '0;
        plane_d = '0;
        if (enable) begin
          rowmax_d = rowmax_in;
          arst_d   = 1'b0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        shift_req_d = 1'b1;
        state_d     = WAIT;
      end
      WAIT: begin
        blank_d = blank_q;
        if (shift_done) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        latch_d = 1'b1;
        state_d = UNBLANK;
      end
      UNBLANK: begin
        blank_d = 1'b0;
        on_load = 1'b1;
        state_d = ON;
      end
      ON: begin
        // Blank rises on the edge leaving the last on-cycle, giving exactly on_time low cycles.
        on_dec  = 1'b1;
        blank_d = (on_value <= PW'(1));
        if (on_expired) begin
          state_d = BLANKING;
        end
      end
      BLANKING: begin
        state_d = ADVANCE;
      end
      ADVANCE: begin
        if (plane_q < PLANE_W'(PLANES - 1)) begin
          plane_d = plane_q + PLANE_W'(1);
          state_d = SHIFT;
        end else begin
          plane_d = '0;
          state_d = enable ? SHIFT : IDLE;
          if (row_q < rowmax_q) begin
            row_d  = row_q + ROW_W'(1);
            aclk_d = 1'b1;
          end else begin
            row_d        = '0;
            arst_d       = 1'b1;
            frame_tick_d = 1'b1;
            rowmax_d     = rowmax_in;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      row_q        <= '0;
      rowmax_q     <= '0;
      plane_q      <= '0;
      shift_req_q  <= 1'b0;
      latch_q      <= 1'b0;
      blank_q      <= 1'b1;
      aclk_q       <= 1'b0;
      arst_q       <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      rowmax_q     <= rowmax_d;
      plane_q      <= plane_d;
      shift_req_q  <= shift_req_d;
      latch_q      <= latch_d;
      blank_q      <= blank_d;
      aclk_q       <= aclk_d;
      arst_q       <= arst_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign shift_req  = shift_req_q;
  assign row_out    = row_q;
  assign plane_out  = plane_q;
  assign latch_out  = latch_q;
  assign blank_out  = blank_q;
  assign aclk_out   = aclk_q;
  assign arst_out   = arst_q;
  assign frame_tick = frame_tick_q;

endmodule
